// File: rtl/llist_fifo_stimulus.sv
// llist_fifo_stimulus
//   Traffic generator for the linked-list FIFO test environment. A clock
//   divider paces decisions; on each tick an LFSR picks a queue and an
//   alloc/dealloc preference, and at most one new request is issued over
//   a req/ack handshake. Per-queue occupancy is tracked so the generator
//   never over-allocates or deallocates from an empty queue.
//
// Ports
//   SYSTEM_CLOCK, SYSTEM_RESET_N  clock, async active-low reset
//   ENABLE                        runs the divider / permits new requests
//   ALLOC_REQ/QID/ACK             allocate handshake (req held until ack)
//   DEALLOC_REQ/QID/ACK           deallocate handshake (req held until ack)
//   OUTSTANDING                   sum of all queue occupancies
//   ALLOC_COUNT, DEALLOC_COUNT    acked operation counters (wrapping)
//   ERROR                         sticky: ack seen with no pending request
module llist_fifo_stimulus #(
    parameter int          DIV_WIDTH = 4,
    parameter int          PTR_WIDTH = 6,
    parameter int          QID_WIDTH = 2,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                 SYSTEM_CLOCK,
    input  logic                 SYSTEM_RESET_N,
    input  logic                 ENABLE,
    output logic                 ALLOC_REQ,
    output logic [QID_WIDTH-1:0] ALLOC_QID,
    input  logic                 ALLOC_ACK,
    output logic                 DEALLOC_REQ,
    output logic [QID_WIDTH-1:0] DEALLOC_QID,
    input  logic                 DEALLOC_ACK,
    output logic [PTR_WIDTH:0]   OUTSTANDING,
    output logic [15:0]          ALLOC_COUNT,
    output logic [15:0]          DEALLOC_COUNT,
    output logic                 ERROR
);

    localparam int NQ = 1 << QID_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH = {1'b1, {PTR_WIDTH{1'b0}}};

    logic [DIV_WIDTH-1:0] div_count;
    logic                 wait_for_alloc_ack;
    logic                 wait_for_dealloc_ack;
    logic [15:0]          lfsr;
    logic [PTR_WIDTH:0]   occ     [NQ];
    logic [PTR_WIDTH:0]   occ_nxt [NQ];

    logic                 tick;
    logic [QID_WIDTH-1:0] q;
    logic [QID_WIDTH-1:0] dq;
    logic [QID_WIDTH-1:0] idx;
    logic                 found;
    logic                 can_alloc;
    logic                 can_dealloc;
    logic                 issue_alloc;
    logic                 issue_dealloc;
    logic                 alloc_done;
    logic                 dealloc_done;

    assign ALLOC_REQ   = wait_for_alloc_ack;
    assign DEALLOC_REQ = wait_for_dealloc_ack;

    assign tick = ENABLE && (div_count == '1);
    assign q    = lfsr[QID_WIDTH:1];

    // Total occupancy never exceeds DEPTH, so the sum fits PTR_WIDTH+1 bits.
    always_comb begin
        OUTSTANDING = '0;
        for (int i = 0; i < NQ; i++) begin
            OUTSTANDING = OUTSTANDING + occ[i];
        end
    end

    // Round-robin search for a non-empty queue starting at q.
    always_comb begin
        dq    = q;
        idx   = q;
        found = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            idx = q + QID_WIDTH'(i);
            if (!found && occ[idx] != '0) begin
                dq    = idx;
                found = 1'b1;
            end
        end
    end

    // Decisions use the pre-ack flags and occupancy, so a channel freed by
    // an ack on this edge is only reusable from the next tick.
    assign can_alloc     = !wait_for_alloc_ack && (OUTSTANDING < DEPTH);
    assign can_dealloc   = !wait_for_dealloc_ack && (OUTSTANDING != '0);
    assign issue_alloc   = tick && can_alloc && (lfsr[0] || !can_dealloc);
    assign issue_dealloc = tick && can_dealloc && (!lfsr[0] || !can_alloc);

    assign alloc_done    = ALLOC_ACK && wait_for_alloc_ack;
    assign dealloc_done  = DEALLOC_ACK && wait_for_dealloc_ack;

    // Both completions may hit the same queue; apply +1 and -1 together.
    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            occ_nxt[i] = occ[i]
                + (PTR_WIDTH+1)'(alloc_done && (ALLOC_QID == QID_WIDTH'(i)))
                - (PTR_WIDTH+1)'(dealloc_done && (DEALLOC_QID == QID_WIDTH'(i)));
        end
    end

    always_ff @(posedge SYSTEM_CLOCK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            div_count            <= '0;
            wait_for_alloc_ack   <= 1'b0;
            wait_for_dealloc_ack <= 1'b0;
            lfsr                 <= SEED;
            ALLOC_QID            <= '0;
            DEALLOC_QID          <= '0;
            ALLOC_COUNT          <= '0;
            DEALLOC_COUNT        <= '0;
            ERROR                <= 1'b0;
            for (int i = 0; i < NQ; i++) begin
                occ[i] <= '0;
            end
        end else begin
            if (ENABLE) begin
                div_count <= div_count + 1'b1;
            end
            if (tick) begin
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end

            // Issue requires the flag clear, so done/issue never collide.
            if (alloc_done) begin
                wait_for_alloc_ack <= 1'b0;
                ALLOC_COUNT        <= ALLOC_COUNT + 16'd1;
            end else if (issue_alloc) begin
                wait_for_alloc_ack <= 1'b1;
                ALLOC_QID          <= q;
            end

            if (dealloc_done) begin
                wait_for_dealloc_ack <= 1'b0;
                DEALLOC_COUNT        <= DEALLOC_COUNT + 16'd1;
            end else if (issue_dealloc) begin
                wait_for_dealloc_ack <= 1'b1;
                DEALLOC_QID          <= dq;
            end

            for (int i = 0; i < NQ; i++) begin
                occ[i] <= occ_nxt[i];
            end

            if ((ALLOC_ACK && !wait_for_alloc_ack) ||
                (DEALLOC_ACK && !wait_for_dealloc_ack)) begin
                ERROR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_llist_fifo_stimulus.sv
// Bench for llist_fifo_stimulus: randomized ack timing/enable against an
// integer-level reference model of the generator's rules.
module tb_llist_fifo_stimulus;

    localparam int DW = 4;
    localparam int PW = 6;
    localparam int QW = 2;
    localparam int NQ = 1 << QW;
    localparam int DEPTH = 1 << PW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          alloc_req;
    logic [QW-1:0] alloc_qid;
    logic          alloc_ack = 1'b0;
    logic          dealloc_req;
    logic [QW-1:0] dealloc_qid;
    logic          dealloc_ack = 1'b0;
    logic [PW:0]   outstanding;
    logic [15:0]   alloc_count;
    logic [15:0]   dealloc_count;
    logic          error;

    llist_fifo_stimulus #(
        .DIV_WIDTH(DW), .PTR_WIDTH(PW), .QID_WIDTH(QW), .SEED(SEED)
    ) dut (
        .SYSTEM_CLOCK  (clk),
        .SYSTEM_RESET_N(rst_n),
        .ENABLE        (en),
        .ALLOC_REQ     (alloc_req),
        .ALLOC_QID     (alloc_qid),
        .ALLOC_ACK     (alloc_ack),
        .DEALLOC_REQ   (dealloc_req),
        .DEALLOC_QID   (dealloc_qid),
        .DEALLOC_ACK   (dealloc_ack),
        .OUTSTANDING   (outstanding),
        .ALLOC_COUNT   (alloc_count),
        .DEALLOC_COUNT (dealloc_count),
        .ERROR         (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (values expected after the most recent edge).
    logic [DW-1:0] m_div;
    logic [15:0]   m_lfsr;
    logic          m_wa, m_wd, m_err;
    logic [QW-1:0] m_aq, m_dq;
    logic [15:0]   m_ac, m_dc;
    int            m_occ [NQ];

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < NQ; i++) s += m_occ[i];
        return s;
    endfunction

    function automatic logic [65:0] dut_vec();
        return {alloc_req, dealloc_req, alloc_qid, dealloc_qid, outstanding,
                alloc_count, dealloc_count, error, dut.div_count, dut.lfsr};
    endfunction

    function automatic logic [65:0] exp_vec();
        int s;
        logic [PW:0] t;
        s = m_total();
        t = s[PW:0];
        return {m_wa, m_wd, m_aq, m_dq, t, m_ac, m_dc, m_err, m_div, m_lfsr};
    endfunction

    task automatic model_reset();
        m_div = '0; m_lfsr = SEED; m_wa = 0; m_wd = 0; m_err = 0;
        m_aq = '0; m_dq = '0; m_ac = '0; m_dc = '0;
        for (int i = 0; i < NQ; i++) m_occ[i] = 0;
    endtask

    // One rising edge of the generator's rules, in plain integer terms.
    task automatic model_edge(input logic e, input logic aa, input logic da);
        bit tick, can_a, can_d, iss_a, iss_d, pend_a, pend_d;
        int tot, q, dq;
        tick   = e && (m_div == '1);
        pend_a = m_wa;
        pend_d = m_wd;
        tot    = m_total();
        q      = int'(m_lfsr[QW:1]);
        dq     = -1;
        for (int k = 0; k < NQ; k++)
            if (dq < 0 && m_occ[(q + k) % NQ] != 0) dq = (q + k) % NQ;
        can_a = !pend_a && tot < DEPTH;
        can_d = !pend_d && tot != 0;
        iss_a = tick && can_a && (m_lfsr[0] || !can_d);
        iss_d = tick && can_d && (!m_lfsr[0] || !can_a);
        if (aa) begin
            if (pend_a) begin m_wa = 0; m_occ[m_aq]++; m_ac++; end
            else m_err = 1;
        end
        if (da) begin
            if (pend_d) begin m_wd = 0; m_occ[m_dq]--; m_dc++; end
            else m_err = 1;
        end
        if (iss_a) begin m_wa = 1; m_aq = m_lfsr[QW:1]; end
        if (iss_d) begin m_wd = 1; m_dq = dq[QW-1:0]; end
        if (tick) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (e) m_div = m_div + 1'b1;
    endtask

    // Drive inputs away from the edge, advance the model, sample #1 after.
    task automatic step(input logic e, input logic aa, input logic da);
        en = e; alloc_ack = aa; dealloc_ack = da;
        model_edge(e, aa, da);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        repeat (3) begin
            en = 1'($urandom); alloc_ack = 1'($urandom); dealloc_ack = 1'($urandom);
            @(negedge clk);
        end
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
        end
        rst_n = 1; en = 0; alloc_ack = 0; dealloc_ack = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({alloc_req, dealloc_req, outstanding, alloc_count, dealloc_count, error} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {alloc_req, dealloc_req, outstanding, alloc_count, dealloc_count, error});
        end
        n_vec++;
        if (dut.lfsr !== 16'hACE1 || dut.div_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_lfsr_div got=%h/%h exp=ace1/0", dut.lfsr, dut.div_count);
        end
    endtask

    task automatic test_pacing();
        do_reset();
        for (int i = 1; i <= 160; i++) begin
            step(1'b1, m_wa, m_wd);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL pacing cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (i == 15 || i == 16) begin
                n_vec++;
                if (alloc_req !== (i == 16)) begin
                    n_err++;
                    $display("FAIL first_alloc cyc=%0d got=%b exp=%b", i, alloc_req, i == 16);
                end
            end
            n_vec++;
            if ({1'b0, alloc_count - dealloc_count} !== {10'd0, outstanding}) begin
                n_err++;
                $display("FAIL count_balance cyc=%0d got=%0d exp=%0d", i,
                         alloc_count - dealloc_count, outstanding);
            end
        end
    endtask

    task automatic test_hold();
        logic [QW-1:0] held;
        logic [PW:0]   prev;
        int guard = 0;
        while (!m_wa && guard < 64) begin
            step(1'b1, 1'b0, m_wd);
            guard++;
        end
        n_vec++;
        if (alloc_req !== 1'b1) begin
            n_err++;
            $display("FAIL hold_reach got=%b exp=1", alloc_req);
        end
        held = m_aq;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, m_wd);
            n_vec++;
            if (alloc_req !== 1'b1 || alloc_qid !== held || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        prev = outstanding;
        step(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (alloc_req !== 1'b0 || outstanding !== prev + 1'b1) begin
            n_err++;
            $display("FAIL hold_release got=%b/%0d exp=0/%0d", alloc_req, outstanding, prev + 1'b1);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 1300; i++) begin
            step(1'b1, m_wa, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec() || (i >= 1100 && alloc_req !== 1'b0)) begin
                n_err++;
                $display("FAIL full cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (outstanding !== 7'd64 || dealloc_req !== 1'b1) begin
            n_err++;
            $display("FAIL full_end got=%0d/%b exp=64/1", outstanding, dealloc_req);
        end
    endtask

    task automatic test_error();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (error !== 1'b1 || alloc_count !== 16'd0 || outstanding !== '0) begin
            n_err++;
            $display("FAIL error_set got=%b/%0d/%0d exp=1/0/0", error, alloc_count, outstanding);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, m_wa, m_wd);
            n_vec++;
            if (error !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL error_sticky cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        n_vec++;
        if (error !== 1'b0 || alloc_count !== 16'd0 || alloc_req !== 1'b0 || dealloc_req !== 1'b0) begin
            n_err++;
            $display("FAIL error_clear got=%b/%0d exp=0/0", error, alloc_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_enable_gating();
        logic [DW-1:0] frozen;
        int guard = 0;
        do_reset();
        while (!m_wd && guard < 600) begin
            step(1'b1, m_wa, 1'b0);
            guard++;
        end
        n_vec++;
        if (dealloc_req !== 1'b1) begin
            n_err++;
            $display("FAIL gate_reach got=%b exp=1", dealloc_req);
        end
        frozen = m_div;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, m_wa, 1'b0);
            n_vec++;
            if (dut.div_count !== frozen || dealloc_req !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL gate_hold cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (dealloc_req !== 1'b0 || dealloc_count !== 16'd1 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL gate_complete got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step(($urandom_range(0, 9) != 0),
                 m_wa && ($urandom_range(0, 2) == 0),
                 m_wd && ($urandom_range(0, 2) == 0));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_pacing();
        test_hold();
        test_full();
        test_error();
        test_enable_gating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/llist_fifo_stimulus.md
# llist_fifo_stimulus

Self-checking traffic generator for the linked-list FIFO (`llist_fifo_big`) test environment. It paces pseudo-random allocate and deallocate requests with a clock divider and drives them over req/ack handshakes. It tracks per-queue occupancy so it never over-allocates or deallocates from an empty queue, and it flags protocol errors. It sits beside the FIFO in the bench top, clocked from the single system clock.

## Interface

- `DIV_WIDTH`, 4: width of the pacing divider `div_count`; one tick every 2^DIV_WIDTH cycles.
- `PTR_WIDTH`, 6: FIFO buffer pointer width; capacity DEPTH = 2^PTR_WIDTH.
- `QID_WIDTH`, 2: queue-id width; NQ = 2^QID_WIDTH queues.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `SYSTEM_CLOCK`  in  1  sole clock; all state changes on the rising edge.
- `SYSTEM_RESET_N`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  allows the divider to run and new requests to issue.
- `ALLOC_REQ`  out  1  allocate request, held until acked.
- `ALLOC_QID`  out  QID_WIDTH  target queue for the allocate.
- `ALLOC_ACK`  in  1  FIFO accepted the allocate.
- `DEALLOC_REQ`  out  1  deallocate request, held until acked.
- `DEALLOC_QID`  out  QID_WIDTH  source queue for the deallocate.
- `DEALLOC_ACK`  in  1  FIFO completed the deallocate.
- `OUTSTANDING`  out  PTR_WIDTH+1  sum of all queue occupancies.
- `ALLOC_COUNT`  out  16  acked allocates, wrapping.
- `DEALLOC_COUNT`  out  16  acked deallocates, wrapping.
- `ERROR`  out  1  sticky protocol-error flag.

## Operation

- Internal registers keep these names so benches can probe them hierarchically: `div_count` (DIV_WIDTH bits), `wait_for_alloc_ack`, `wait_for_dealloc_ack`, `lfsr` (16 bits), `occ[NQ]` (PTR_WIDTH+1 bits each).
- Reset values:
  - `div_count`, the wait flags, `occ`, all counters and all outputs = 0.
  - `lfsr` = SEED.
  - `ALLOC_REQ` = `ALLOC_REQ`'s mirror `wait_for_alloc_ack`; `DEALLOC_REQ` mirrors `wait_for_dealloc_ack`.
- Divider:
  - When ENABLE=1, `div_count` increments and wraps at 2^DIV_WIDTH−1.
  - When ENABLE=0, `div_count` holds.
  - tick = ENABLE && `div_count` == all-ones.
- LFSR:
  - Advances only on tick.
  - Fibonacci, taps 16,14,13,11: new bit0 = b15^b13^b12^b10, shift left.
- Decision on tick, using the pre-advance `lfsr`: q = `lfsr`[QID_WIDTH:1].
  - can_alloc = !`wait_for_alloc_ack` && OUTSTANDING < DEPTH.
  - dq = first queue with `occ`≠0, scanning q, q+1, … modulo NQ.
  - can_dealloc = !`wait_for_dealloc_ack` && OUTSTANDING ≠ 0.
  - If `lfsr`[0]=1, prefer alloc; otherwise prefer dealloc. Issue the preferred operation if possible, else the other if possible, else nothing.
  - At most one new request per tick.
- Issue alloc: set `wait_for_alloc_ack`, ALLOC_QID←q.
- Issue dealloc: set `wait_for_dealloc_ack`, DEALLOC_QID←dq.
- QIDs are held stable while the corresponding request is pending.
- Completion:
  - ALLOC_ACK sampled with `wait_for_alloc_ack`=1: clear the flag, `occ`[ALLOC_QID]+1, ALLOC_COUNT+1.
  - DEALLOC_ACK sampled with `wait_for_dealloc_ack`=1: clear the flag, `occ`[DEALLOC_QID]−1, DEALLOC_COUNT+1.
  - Both acks in the same cycle: both apply. OUTSTANDING is unchanged if the QIDs match; otherwise net zero.
- An alloc and a dealloc may both be pending at once. Pending requests complete even when ENABLE=0.
- ERROR sets on an ALLOC_ACK without a pending alloc, or a DEALLOC_ACK without a pending dealloc. It clears only on reset. The stray ack causes no other state change.

## Timing

- The request is registered on the tick edge: the REQ line is high starting the cycle after that edge.
- With reset release and ENABLE=1 from cycle 0, the first tick is at the 2^DIV_WIDTH-th rising edge.
- An ack is sampled on a rising edge. REQ is low after that same edge, and counters and OUTSTANDING update on that edge.
- Minimum REQ width is 1 cycle, when the ack is returned combinationally.
- A tick on the ack edge sees the pre-ack wait flags and `occ`. A freed channel is therefore reusable at the next tick.
- Reset asserted mid-operation: everything clears immediately and pending requests are dropped, with no ack expected.

## Test plan

- Reset: hold SYSTEM_RESET_N=0 with random acks -> all outputs 0, `div_count`=0, `lfsr`=16'hACE1, ERROR=0.
- Pacing: ENABLE=1, both acks tied 1 -> a single 1-cycle REQ pulse every 16 cycles. The first is an ALLOC_REQ (queues empty) after the 16th edge. ALLOC_COUNT−DEALLOC_COUNT always equals OUTSTANDING.
- Hold: ALLOC_ACK withheld 40 cycles -> ALLOC_REQ and ALLOC_QID constant, no second alloc, deallocs still issue. Pulsing ALLOC_ACK once -> ALLOC_REQ drops on the next edge and OUTSTANDING+1.
- Full: DEALLOC_ACK tied 0, ALLOC_ACK tied 1 -> OUTSTANDING saturates at 64 and no ALLOC_REQ appears afterwards. DEALLOC_REQ stays high.
- Error: ALLOC_ACK pulsed for 1 cycle with ALLOC_REQ=0 -> ERROR=1 from the next edge, sticky through 100 cycles. Counters unchanged; cleared by reset.
- Enable gating: ENABLE dropped while a dealloc is pending -> `div_count` frozen and no new REQ. The pending dealloc completes on DEALLOC_ACK.
